// File: rtl/noc_port_allocator_pkg.sv
// Shared constants and FSM state type for the NoC output-port allocator.
package Noc_parameters;

    localparam int Noc_VC_Channel  = 4;
    localparam int NOC_WDOG_CYCLES = 1024;

    typedef enum logic [0:0] {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

    // Index width for a CHANNELS-wide vector; never narrower than one bit.
    function automatic int noc_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/noc_port_allocator_if.sv
// Request/grant bundle between input VCs (master) and the port allocator (slave).
interface noc_port_allocator_if
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
);
    localparam int IDX_W = noc_idx_w(CHANNELS);

    logic [CHANNELS-1:0] request;
    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] start_of_packet;
    logic [CHANNELS-1:0] end_of_packet;
    logic [CHANNELS-1:0] grant;
    logic                busy;
    logic [IDX_W-1:0]    owner;
    logic                wdog_err;

    modport master (
        output request, free, start_of_packet, end_of_packet,
        input  grant, busy, owner, wdog_err
    );

    modport slave (
        input  request, free, start_of_packet, end_of_packet,
        output grant, busy, owner, wdog_err
    );

endinterface

// File: rtl/noc_port_allocator_rr_picker.sv
// Combinational round-robin picker: first set candidate at or after i_ptr, wrapping.
module noc_rr_picker
    import Noc_parameters::*;
#(
    parameter int CHANNELS = Noc_VC_Channel
) (
    input  logic [CHANNELS-1:0]           i_cand,
    input  logic [noc_idx_w(CHANNELS)-1:0] i_ptr,
    output logic [CHANNELS-1:0]           o_onehot,
    output logic [noc_idx_w(CHANNELS)-1:0] o_index,
    output logic                          o_any
);
    localparam int IDX_W = noc_idx_w(CHANNELS);

    int               w_sum;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        o_any    = 1'b0;
        w_sum    = 0;
        w_idx    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_sum = int'(i_ptr) + i;
            if (w_sum >= CHANNELS) begin
                w_sum = w_sum - CHANNELS;
            end
            w_idx = IDX_W'(w_sum);
            if (!o_any && i_cand[w_idx]) begin
                o_any           = 1'b1;
                o_onehot[w_idx] = 1'b1;
                o_index         = w_idx;
            end
        end
    end

endmodule

// File: rtl/noc_port_allocator.sv
// Packet-granular round-robin allocator of one NoC output port among CHANNELS VCs.
// Optional stall watchdog is enabled by defining NOC_PORT_ALLOC_WATCHDOG_EN.
module noc_port_allocator
    import Noc_parameters::*;
#(
    parameter int CHANNELS    = Noc_VC_Channel,
    parameter int WDOG_CYCLES = NOC_WDOG_CYCLES
) (
    input  logic                 noc_clk,
    input  logic                 noc_rst,
    noc_port_allocator_if.slave  bus
);
    localparam int IDX_W = noc_idx_w(CHANNELS);

    alloc_state_e        r_state;
    logic [CHANNELS-1:0] r_grant;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic                r_busy;

    logic [CHANNELS-1:0] w_cand;
    logic [CHANNELS-1:0] w_pick_cand;
    logic [CHANNELS-1:0] w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_ptr;
    logic [IDX_W-1:0]    w_pick_index;
    logic [IDX_W-1:0]    w_next_ptr;
    logic                w_pick_any;
    logic                w_done;
    logic                w_trip;

    assign w_cand     = bus.request & bus.start_of_packet;
    assign w_next_ptr = (r_owner == IDX_W'(CHANNELS - 1)) ? '0 : r_owner + IDX_W'(1);
    assign w_done     = (r_state == ALLOC_LOCKED) && bus.end_of_packet[r_owner];

    // While locked the picker only matters on packet done, so it already looks past the owner.
    assign w_pick_cand = (r_state == ALLOC_IDLE) ? w_cand : (w_cand & ~r_grant);
    assign w_pick_ptr  = (r_state == ALLOC_IDLE) ? r_rr_ptr : w_next_ptr;

    noc_rr_picker #(.CHANNELS(CHANNELS)) u_picker (
        .i_cand   (w_pick_cand),
        .i_ptr    (w_pick_ptr),
        .o_onehot (w_pick_onehot),
        .o_index  (w_pick_index),
        .o_any    (w_pick_any)
    );

`ifdef NOC_PORT_ALLOC_WATCHDOG_EN
    localparam int STALL_W = $clog2(WDOG_CYCLES + 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_wdog_err;
    logic               w_stall;

    assign w_stall = (r_state == ALLOC_LOCKED) && !(bus.request[r_owner] && bus.free[r_owner]);
    // A completing packet wins over a simultaneous timeout.
    assign w_trip  = w_stall && (r_stall == STALL_W'(WDOG_CYCLES - 1)) && !w_done;
    assign bus.wdog_err = r_wdog_err;
`else
    logic w_unused_wdog;

    assign w_unused_wdog = ^{bus.free, (WDOG_CYCLES > 0)};
    assign w_trip        = 1'b0;
    assign bus.wdog_err  = 1'b0;
`endif

    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            r_state  <= ALLOC_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_rr_ptr <= '0;
            r_busy   <= 1'b0;
`ifdef NOC_PORT_ALLOC_WATCHDOG_EN
            r_stall    <= '0;
            r_wdog_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                ALLOC_IDLE: begin
                    if (w_pick_any) begin
                        r_state <= ALLOC_LOCKED;
                        r_grant <= w_pick_onehot;
                        r_owner <= w_pick_index;
                        r_busy  <= 1'b1;
                    end
                end
                ALLOC_LOCKED: begin
                    if (w_done || w_trip) begin
                        r_rr_ptr <= w_next_ptr;
                        if (w_done && w_pick_any) begin
                            r_grant <= w_pick_onehot;
                            r_owner <= w_pick_index;
                        end else begin
                            r_state <= ALLOC_IDLE;
                            r_grant <= '0;
                            r_owner <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= ALLOC_IDLE;
                    r_grant <= '0;
                    r_owner <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
`ifdef NOC_PORT_ALLOC_WATCHDOG_EN
            if (w_trip) begin
                r_wdog_err <= 1'b1;
            end
            if ((r_state != ALLOC_LOCKED) || w_done || w_trip) begin
                r_stall <= '0;
            end else if (w_stall) begin
                r_stall <= r_stall + STALL_W'(1);
            end
`endif
        end
    end

    assign bus.grant = r_grant;
    assign bus.busy  = r_busy;
    assign bus.owner = r_owner;

endmodule

// File: doc/noc_port_allocator.md
NOC_PORT_ALLOCATOR -- requirements
Module: noc_port_allocator

Interface
REQ-001 SHALL have parameter CHANNELS, default Noc_VC_Channel; the number of input VC requesters contending for one output port.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1024; the stall limit used by the watchdog (Configuration).
REQ-003 SHALL have port noc_clk, input, 1; the single clock, with all state updated on its rising edge.
REQ-004 SHALL have port noc_rst, input, 1; the reset, synchronous and active-high.
REQ-005 SHALL have port request, input, CHANNELS; per-VC flit valid targeting this port.
REQ-006 SHALL have port free, input, CHANNELS; per-VC downstream-ready seen by the requesting VC.
REQ-007 SHALL have port start_of_packet, input, CHANNELS; per-VC header flit valid.
REQ-008 SHALL have port end_of_packet, input, CHANNELS; per-VC tail flit accepted (valid & ready).
REQ-009 SHALL have port grant, output, CHANNELS; one-hot or zero VC ownership of the port.
REQ-010 SHALL have port busy, output, 1; high while any VC owns the port.
REQ-011 SHALL have port owner, output, $clog2(CHANNELS) (min 1); index of the current owner, 0 when idle.
REQ-012 SHALL have port wdog_err, output, 1; sticky watchdog error flag.

Function
REQ-013 SHALL use a two-state FSM: IDLE (grant=0) and LOCKED (grant=onehot(owner)).
REQ-014 SHALL, in IDLE, form candidates = request & start_of_packet; if candidates is nonzero, select a winner round-robin starting at index rr_ptr, wrapping CHANNELS-1→0.
REQ-015 SHALL register the winner, giving one-cycle latency: grant, owner and busy assert on the cycle after the header is presented, and the FSM enters LOCKED.
REQ-016 SHALL, in LOCKED, hold grant constant and ignore all non-owner start_of_packet bits.
REQ-017 SHALL treat end_of_packet[owner] in LOCKED as the packet-done event; end_of_packet on non-owner bits, or end_of_packet in IDLE, SHALL be ignored.
REQ-018 SHALL, on packet done, set rr_ptr = (owner+1) mod CHANNELS.
REQ-019 SHALL, on packet done when candidates excluding the owner are nonzero, re-arbitrate in the same cycle from the new rr_ptr and remain LOCKED with the new owner next cycle, with no idle bubble.
REQ-020 SHALL, on packet done with no other candidate, return to IDLE with grant=0 next cycle.
REQ-021 SHALL handle a single-flit packet as follows: after grant, a simultaneous request & start_of_packet & end_of_packet on the owner completes the packet in that cycle.
REQ-022 SHALL never assert more than one grant bit in any cycle.
REQ-023 SHALL grant a requester that holds start_of_packet within CHANNELS packet completions (starvation-free).

Reset
REQ-024 SHALL, while noc_rst is high at a noc_clk edge, drive grant=0, busy=0, owner=0, wdog_err=0, rr_ptr=0, state=IDLE and stall counter=0.
REQ-025 SHALL, when reset is asserted mid-packet, drop ownership on the next edge; the partial packet is not resumed.
REQ-026 SHALL be able to grant on the first cycle after reset deasserts.

Configuration
REQ-027 SHALL, with NOC_PORT_ALLOC_WATCHDOG_EN defined, run a stall counter: in LOCKED it increments each cycle in which !(request[owner] & free[owner]), and clears on any owner transfer or state change.
REQ-028 SHALL, with the watchdog enabled, when the counter reaches WDOG_CYCLES, set wdog_err (sticky until reset), force the FSM to IDLE, and advance rr_ptr past the owner.
REQ-029 SHALL, without NOC_PORT_ALLOC_WATCHDOG_EN, contain no counter logic, tie wdog_err to 0, and hold ownership indefinitely.

Structure
REQ-030 SHALL place the FSM state enum (ALLOC_IDLE, ALLOC_LOCKED) and the WDOG_CYCLES default constant in Noc_parameters.
REQ-031 SHALL implement the winner selection in a sub-module noc_rr_picker (combinational: candidates, rr_ptr → onehot and index).

Verification
REQ-032 SHALL verify single requester: VC0 presents a header at cycle 0 → grant=0001 at cycle 1; end_of_packet[0] at cycle 4 → grant=0000 at cycle 5.
REQ-033 SHALL verify contention: VC1 and VC2 present headers together with rr_ptr=0 → VC1 granted; at VC1's end_of_packet, VC2 is granted the very next cycle with no bubble.
REQ-034 SHALL verify fairness: all 4 VCs continuously send 2-flit packets → grant order 0,1,2,3,0 and no VC waits more than 3 packets.
REQ-035 SHALL verify isolation: end_of_packet[2] while VC0 owns the port → grant stays 0001, and a stray header on VC3 is ignored.
REQ-036 SHALL verify the watchdog (macro on, WDOG_CYCLES=8): the owner stalls with free=0 for 8 cycles → wdog_err=1, grant=0; with the macro off → grant held and wdog_err=0.
REQ-037 SHALL verify mid-packet reset: noc_rst pulses in LOCKED → next cycle grant=0, busy=0, owner=0, and a new header is granted from VC0 priority.
